alu_operand_issue: RTL and testbench

- Registered issue stage that sits in front of the `alu` and drives its operand and control inputs.
- Accepts one decoded instruction per handshake from the decode stage.
- Resolves operands from register-file data, the EX/MEM and MEM/WB forwarding paths, the PC, or the immediate, then holds them stable for the ALU until the downstream consumer accepts.
- Detects load-use hazards and inserts bubbles.

---
 rtl/alu_operand_issue.sv | 164 ++++++++++++++++
 tb/tb_alu_operand_issue.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_issue.sv
// Registered operand-issue stage ahead of the ALU: forwarding mux, load-use bubble, flush.
// Optional performance counters are enabled by defining ALU_ISSUE_PERF_EN.
module alu_operand_issue #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [REG_AW-1:0] i_rs1_addr,
    input  logic [REG_AW-1:0] i_rs2_addr,
    input  logic [XLEN-1:0]   i_rs1_data,
    input  logic [XLEN-1:0]   i_rs2_data,
    input  logic [XLEN-1:0]   i_pc,
    input  logic [XLEN-1:0]   i_imm,
    input  logic              i_alusrc_a,
    input  logic              i_alusrc_b,
    input  logic [2:0]        i_alucontrol,
    input  logic [REG_AW-1:0] i_rd_addr,
    input  logic              i_regwrite,
    input  logic              i_memread,
    input  logic [REG_AW-1:0] i_exmem_rd,
    input  logic              i_exmem_regwrite,
    input  logic [XLEN-1:0]   i_exmem_result,
    input  logic [REG_AW-1:0] i_memwb_rd,
    input  logic              i_memwb_regwrite,
    input  logic [XLEN-1:0]   i_memwb_result,
    input  logic              i_flush,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [XLEN-1:0]   o_a,
    output logic [XLEN-1:0]   o_b,
    output logic [2:0]        o_alucontrol,
    output logic [XLEN-1:0]   o_rs2_fwd,
    output logic [REG_AW-1:0] o_rd_addr,
    output logic              o_regwrite,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]       o_stall_cycles,
    output logic [31:0]       o_fwd_hits,
`endif
    output logic              o_memread
);

    logic              valid_reg, valid_next;
    logic              stall_cnt_reg, stall_cnt_next;
    logic [XLEN-1:0]   a_reg, b_reg, rs2_fwd_reg;
    logic [2:0]        alucontrol_reg;
    logic [REG_AW-1:0] rd_reg;
    logic              regwrite_reg, memread_reg;

    logic              haz_now, stall, accept, fire;

    logic [REG_AW-1:0] src_addr [2];
    logic [XLEN-1:0]   src_data [2];
    logic [XLEN-1:0]   fwd_val  [2];

    assign src_addr[0] = i_rs1_addr;
    assign src_addr[1] = i_rs2_addr;
    assign src_data[0] = i_rs1_data;
    assign src_data[1] = i_rs2_data;

`ifdef ALU_ISSUE_PERF_EN
    logic [1:0] fwd_hit;
`endif

    // x0 always reads zero; EX/MEM is the younger result so it wins over MEM/WB.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fwd
            logic hit_exmem, hit_memwb;
            assign hit_exmem = i_exmem_regwrite && (i_exmem_rd == src_addr[gi]);
            assign hit_memwb = i_memwb_regwrite && (i_memwb_rd == src_addr[gi]);
            assign fwd_val[gi] = (src_addr[gi] == '0) ? '0 :
                                 hit_exmem           ? i_exmem_result :
                                 hit_memwb           ? i_memwb_result :
                                                       src_data[gi];
`ifdef ALU_ISSUE_PERF_EN
            assign fwd_hit[gi] = (src_addr[gi] != '0) && (hit_exmem || hit_memwb);
`endif
        end
    endgenerate

    assign haz_now = valid_reg && memread_reg && (rd_reg != '0) && i_valid &&
                     ((rd_reg == i_rs1_addr) || (rd_reg == i_rs2_addr));
    assign stall   = haz_now || stall_cnt_reg;
    assign o_ready = (!valid_reg || i_ready) && !stall && !i_flush;
    assign accept  = i_valid && o_ready;
    assign fire    = valid_reg && i_ready;

    always_comb begin
        valid_next     = valid_reg;
        stall_cnt_next = stall_cnt_reg;
        if (i_flush) begin
            valid_next     = 1'b0;
            stall_cnt_next = 1'b0;
        end else begin
            if (accept)
                valid_next = 1'b1;
            else if (fire)
                valid_next = 1'b0;
            // The bubble is counted from the cycle the load actually leaves.
            if (haz_now && fire)
                stall_cnt_next = 1'b1;
            else if (stall_cnt_reg)
                stall_cnt_next = stall_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            valid_reg      <= 1'b0;
            stall_cnt_reg  <= 1'b0;
            a_reg          <= '0;
            b_reg          <= '0;
            rs2_fwd_reg    <= '0;
            alucontrol_reg <= 3'b000;
            rd_reg         <= '0;
            regwrite_reg   <= 1'b0;
            memread_reg    <= 1'b0;
        end else begin
            valid_reg     <= valid_next;
            stall_cnt_reg <= stall_cnt_next;
            if (accept) begin
                a_reg          <= i_alusrc_a ? i_pc  : fwd_val[0];
                b_reg          <= i_alusrc_b ? i_imm : fwd_val[1];
                rs2_fwd_reg    <= fwd_val[1];
                alucontrol_reg <= i_alucontrol;
                rd_reg         <= i_rd_addr;
                regwrite_reg   <= i_regwrite;
                memread_reg    <= i_memread;
            end
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] stall_cycles_reg, fwd_hits_reg;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cycles_reg <= '0;
            fwd_hits_reg     <= '0;
        end else begin
            if (i_valid && stall)
                stall_cycles_reg <= stall_cycles_reg + 32'd1;
            if (accept && (|fwd_hit))
                fwd_hits_reg <= fwd_hits_reg + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cycles_reg;
    assign o_fwd_hits     = fwd_hits_reg;
`endif

    assign o_valid      = valid_reg;
    assign o_a          = a_reg;
    assign o_b          = b_reg;
    assign o_rs2_fwd    = rs2_fwd_reg;
    assign o_alucontrol = alucontrol_reg;
    assign o_rd_addr    = rd_reg;
    assign o_regwrite   = regwrite_reg;
    assign o_memread    = memread_reg;

endmodule

// File: tb/tb_alu_operand_issue.sv
// Self-checking bench for alu_operand_issue: vector table with a scoreboard queue,
// plus hand-written load-use, backpressure/flush and reset sequences.
module tb_alu_operand_issue;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] rs2f;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
    } exp_t;

    typedef struct {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        asa;
        logic        asb;
        logic [2:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic [4:0]  ex_rd;
        logic        ex_rw;
        logic [31:0] ex_res;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic [31:0] wb_res;
        exp_t        exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [4:0]  i_rs1_addr = '0, i_rs2_addr = '0, i_rd_addr = '0;
    logic [31:0] i_rs1_data = '0, i_rs2_data = '0, i_pc = '0, i_imm = '0;
    logic        i_alusrc_a = 1'b0, i_alusrc_b = 1'b0;
    logic [2:0]  i_alucontrol = '0;
    logic        i_regwrite = 1'b0, i_memread = 1'b0;
    logic [4:0]  i_exmem_rd = '0, i_memwb_rd = '0;
    logic        i_exmem_regwrite = 1'b0, i_memwb_regwrite = 1'b0;
    logic [31:0] i_exmem_result = '0, i_memwb_result = '0;
    logic        i_flush = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_a, o_b, o_rs2_fwd;
    logic [2:0]  o_alucontrol;
    logic [4:0]  o_rd_addr;
    logic        o_regwrite, o_memread;

    always #5 clk = ~clk;

    alu_operand_issue #(.XLEN(32), .REG_AW(5)) dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
        .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
        .i_pc(i_pc), .i_imm(i_imm), .i_alusrc_a(i_alusrc_a), .i_alusrc_b(i_alusrc_b),
        .i_alucontrol(i_alucontrol), .i_rd_addr(i_rd_addr),
        .i_regwrite(i_regwrite), .i_memread(i_memread),
        .i_exmem_rd(i_exmem_rd), .i_exmem_regwrite(i_exmem_regwrite),
        .i_exmem_result(i_exmem_result),
        .i_memwb_rd(i_memwb_rd), .i_memwb_regwrite(i_memwb_regwrite),
        .i_memwb_result(i_memwb_result),
        .i_flush(i_flush), .o_valid(o_valid), .i_ready(i_ready),
        .o_a(o_a), .o_b(o_b), .o_alucontrol(o_alucontrol), .o_rs2_fwd(o_rs2_fwd),
        .o_rd_addr(o_rd_addr), .o_regwrite(o_regwrite), .o_memread(o_memread)
    );

    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   txn_cnt = 0;
    exp_t cur_exp;
    exp_t sb[$];
    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Scoreboard: pop on every output handshake, push on every input handshake.
    task automatic mon();
        exp_t e;
        if (o_valid && i_ready) begin
            check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                $display("txn %0d: a=%h b=%h rs2f=%h ctl=%0d rd=%0d rw=%0b mr=%0b",
                         txn_cnt, o_a, o_b, o_rs2_fwd, o_alucontrol, o_rd_addr,
                         o_regwrite, o_memread);
                txn_cnt++;
                check("sb_a", o_a, e.a);
                check("sb_b", o_b, e.b);
                check("sb_rs2f", o_rs2_fwd, e.rs2f);
                check("sb_ctl", {29'd0, o_alucontrol}, {29'd0, e.ctl});
                check("sb_rd", {27'd0, o_rd_addr}, {27'd0, e.rd});
                check("sb_rw", {31'd0, o_regwrite}, {31'd0, e.rw});
                check("sb_mr", {31'd0, o_memread}, {31'd0, e.mr});
            end
        end
        if (i_valid && o_ready) sb.push_back(cur_exp);
    endtask

    task automatic to_neg();
        @(negedge clk);
        mon();
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        i_valid          = 1'b1;
        i_rs1_addr       = v.rs1;
        i_rs2_addr       = v.rs2;
        i_rs1_data       = v.rs1_data;
        i_rs2_data       = v.rs2_data;
        i_pc             = v.pc;
        i_imm            = v.imm;
        i_alusrc_a       = v.asa;
        i_alusrc_b       = v.asb;
        i_alucontrol     = v.ctl;
        i_rd_addr        = v.rd;
        i_regwrite       = v.rw;
        i_memread        = v.mr;
        i_exmem_rd       = v.ex_rd;
        i_exmem_regwrite = v.ex_rw;
        i_exmem_result   = v.ex_res;
        i_memwb_rd       = v.wb_rd;
        i_memwb_regwrite = v.wb_rw;
        i_memwb_result   = v.wb_res;
        cur_exp          = v.exp;
    endtask

    function automatic vec_t blank();
        vec_t v;
        v = '{rs1:5'd0, rs2:5'd0, rs1_data:32'd0, rs2_data:32'd0, pc:32'd0, imm:32'd0,
              asa:1'b0, asb:1'b0, ctl:3'd0, rd:5'd0, rw:1'b0, mr:1'b0,
              ex_rd:5'd0, ex_rw:1'b0, ex_res:32'd0, wb_rd:5'd0, wb_rw:1'b0, wb_res:32'd0,
              exp:'{a:32'd0, b:32'd0, rs2f:32'd0, ctl:3'd0, rd:5'd0, rw:1'b0, mr:1'b0}};
        return v;
    endfunction

    initial begin
        vec_t v;

        // EX/MEM beats MEM/WB for the same register
        vecs[0] = '{rs1:5'd5, rs2:5'd3, rs1_data:32'h11, rs2_data:32'h77, pc:32'h0, imm:32'h4,
                    asa:1'b0, asb:1'b1, ctl:3'd0, rd:5'd10, rw:1'b1, mr:1'b0,
                    ex_rd:5'd5, ex_rw:1'b1, ex_res:32'h22, wb_rd:5'd5, wb_rw:1'b1, wb_res:32'h33,
                    exp:'{a:32'h22, b:32'h4, rs2f:32'h77, ctl:3'd0, rd:5'd10, rw:1'b1, mr:1'b0}};
        // x0 source never forwards
        vecs[1] = '{rs1:5'd1, rs2:5'd0, rs1_data:32'h100, rs2_data:32'h55, pc:32'h0, imm:32'h0,
                    asa:1'b0, asb:1'b0, ctl:3'd2, rd:5'd11, rw:1'b0, mr:1'b0,
                    ex_rd:5'd0, ex_rw:1'b1, ex_res:32'hFFFF_FFFF, wb_rd:5'd0, wb_rw:1'b0, wb_res:32'h0,
                    exp:'{a:32'h100, b:32'h0, rs2f:32'h0, ctl:3'd2, rd:5'd11, rw:1'b0, mr:1'b0}};
        // MEM/WB used when EX/MEM does not write
        vecs[2] = '{rs1:5'd2, rs2:5'd9, rs1_data:32'h1, rs2_data:32'h2, pc:32'h0, imm:32'h0,
                    asa:1'b0, asb:1'b0, ctl:3'd7, rd:5'd12, rw:1'b1, mr:1'b0,
                    ex_rd:5'd9, ex_rw:1'b0, ex_res:32'hDEAD, wb_rd:5'd9, wb_rw:1'b1, wb_res:32'hBEEF,
                    exp:'{a:32'h1, b:32'hBEEF, rs2f:32'hBEEF, ctl:3'd7, rd:5'd12, rw:1'b1, mr:1'b0}};
        // PC and immediate select; store data still forwarded
        vecs[3] = '{rs1:5'd4, rs2:5'd4, rs1_data:32'h44, rs2_data:32'h44, pc:32'h1000, imm:32'hFFFF_F800,
                    asa:1'b1, asb:1'b1, ctl:3'd5, rd:5'd13, rw:1'b1, mr:1'b0,
                    ex_rd:5'd4, ex_rw:1'b1, ex_res:32'h99, wb_rd:5'd0, wb_rw:1'b0, wb_res:32'h0,
                    exp:'{a:32'h1000, b:32'hFFFF_F800, rs2f:32'h99, ctl:3'd5, rd:5'd13, rw:1'b1, mr:1'b0}};
        // Address matches without regwrite fall back to register file
        vecs[4] = '{rs1:5'd6, rs2:5'd6, rs1_data:32'hA, rs2_data:32'hA, pc:32'h0, imm:32'h0,
                    asa:1'b0, asb:1'b0, ctl:3'd6, rd:5'd14, rw:1'b0, mr:1'b0,
                    ex_rd:5'd6, ex_rw:1'b0, ex_res:32'h66, wb_rd:5'd6, wb_rw:1'b0, wb_res:32'h67,
                    exp:'{a:32'hA, b:32'hA, rs2f:32'hA, ctl:3'd6, rd:5'd14, rw:1'b0, mr:1'b0}};
        // Different paths for rs1 and rs2
        vecs[5] = '{rs1:5'd3, rs2:5'd8, rs1_data:32'h3, rs2_data:32'h8, pc:32'h0, imm:32'h0,
                    asa:1'b0, asb:1'b0, ctl:3'd4, rd:5'd15, rw:1'b1, mr:1'b0,
                    ex_rd:5'd8, ex_rw:1'b1, ex_res:32'h8888, wb_rd:5'd3, wb_rw:1'b1, wb_res:32'h3333,
                    exp:'{a:32'h3333, b:32'h8888, rs2f:32'h8888, ctl:3'd4, rd:5'd15, rw:1'b1, mr:1'b0}};

        cur_exp = blank().exp;

        // Reset state
        to_pos();
        to_pos();
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_a", o_a, 32'd0);
        check("rst_b", o_b, 32'd0);
        check("rst_ctl", {29'd0, o_alucontrol}, 32'd0);
        i_rst = 1'b0;
        to_neg();
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        to_pos();

        // Table vectors back to back: also the throughput check
        i_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i]);
            to_neg();
            check("tput_ready", {31'd0, o_ready}, 32'd1);
            if (i > 0) check("tput_valid", {31'd0, o_valid}, 32'd1);
            to_pos();
        end
        i_valid = 1'b0;
        to_neg();
        check("tput_last_valid", {31'd0, o_valid}, 32'd1);
        to_pos();
        to_neg();
        check("drain_valid", {31'd0, o_valid}, 32'd0);
        to_pos();

        // Load-use: load rd=7 followed by a consumer of x7
        v = blank();
        v.rs1 = 5'd1; v.rs1_data = 32'h5; v.rs2 = 5'd2; v.rs2_data = 32'h6;
        v.asb = 1'b1; v.imm = 32'h8; v.rd = 5'd7; v.rw = 1'b1; v.mr = 1'b1;
        v.exp = '{a:32'h5, b:32'h8, rs2f:32'h6, ctl:3'd0, rd:5'd7, rw:1'b1, mr:1'b1};
        drive(v);
        to_neg();
        to_pos();
        v = blank();
        v.rs1 = 5'd7; v.rs1_data = 32'h1; v.rd = 5'd8; v.rw = 1'b1;
        v.wb_rd = 5'd7; v.wb_rw = 1'b1; v.wb_res = 32'hABCD;
        v.exp = '{a:32'hABCD, b:32'h0, rs2f:32'h0, ctl:3'd0, rd:5'd8, rw:1'b1, mr:1'b0};
        drive(v);
        to_neg();
        check("lu_ready_c0", {31'd0, o_ready}, 32'd0);
        to_pos();
        to_neg();
        check("lu_ready_c1", {31'd0, o_ready}, 32'd0);
        check("lu_bubble_valid", {31'd0, o_valid}, 32'd0);
        to_pos();
        to_neg();
        check("lu_ready_c2", {31'd0, o_ready}, 32'd1);
        to_pos();
        i_valid = 1'b0;
        to_neg();
        check("lu_a", o_a, 32'hABCD);
        to_pos();

        // Load to x0 never creates a hazard
        v = blank();
        v.asb = 1'b1; v.imm = 32'h10; v.mr = 1'b1;
        v.exp = '{a:32'h0, b:32'h10, rs2f:32'h0, ctl:3'd0, rd:5'd0, rw:1'b0, mr:1'b1};
        drive(v);
        to_neg();
        to_pos();
        v = blank();
        v.asb = 1'b1; v.imm = 32'h20; v.ctl = 3'd3;
        v.exp = '{a:32'h0, b:32'h20, rs2f:32'h0, ctl:3'd3, rd:5'd0, rw:1'b0, mr:1'b0};
        drive(v);
        to_neg();
        check("x0_load_ready", {31'd0, o_ready}, 32'd1);
        to_pos();
        i_valid = 1'b0;
        to_neg();
        to_pos();

        // Backpressure then flush
        i_ready = 1'b0;
        v = blank();
        v.rs1 = 5'd1; v.rs1_data = 32'd10; v.rs2 = 5'd2; v.rs2_data = 32'd3; v.ctl = 3'd1;
        v.rd = 5'd4; v.rw = 1'b1;
        v.exp = '{a:32'd10, b:32'd3, rs2f:32'd3, ctl:3'd1, rd:5'd4, rw:1'b1, mr:1'b0};
        drive(v);
        to_neg();
        to_pos();
        i_valid = 1'b0;
        i_rs1_data = 32'hDEAD_0000;
        i_rs2_data = 32'h0000_BEEF;
        for (int i = 0; i < 3; i++) begin
            to_neg();
            check("bp_valid", {31'd0, o_valid}, 32'd1);
            check("bp_a", o_a, 32'd10);
            check("bp_b", o_b, 32'd3);
            check("bp_ctl", {29'd0, o_alucontrol}, 32'd1);
            to_pos();
        end
        v.rs1_data = 32'h55;
        drive(v);
        i_flush = 1'b1;
        i_ready = 1'b1;
        to_neg();
        check("flush_ready", {31'd0, o_ready}, 32'd0);
        to_pos();
        i_flush = 1'b0;
        i_valid = 1'b0;
        to_neg();
        check("flush_valid", {31'd0, o_valid}, 32'd0);
        to_pos();
        to_neg();
        check("flush_drop_valid", {31'd0, o_valid}, 32'd0);
        sb.delete();
        to_pos();

        // Asynchronous reset with a held entry
        i_ready = 1'b0;
        v = blank();
        v.rs1 = 5'd9; v.rs1_data = 32'h1234; v.rs2 = 5'd10; v.rs2_data = 32'h5678; v.ctl = 3'd4;
        v.exp = '{a:32'h1234, b:32'h5678, rs2f:32'h5678, ctl:3'd4, rd:5'd0, rw:1'b0, mr:1'b0};
        drive(v);
        to_neg();
        to_pos();
        i_valid = 1'b0;
        check("pre_rst_valid", {31'd0, o_valid}, 32'd1);
        #1;
        i_rst = 1'b1;
        #1;
        check("arst_valid", {31'd0, o_valid}, 32'd0);
        check("arst_a", o_a, 32'd0);
        check("arst_b", o_b, 32'd0);
        check("arst_rs2f", o_rs2_fwd, 32'd0);
        to_neg();
        sb.delete();
        to_pos();
        i_rst = 1'b0;
        to_neg();
        check("arst_ready", {31'd0, o_ready}, 32'd1);
        to_pos();

        check("sb_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got no end, expected end");
        $fatal(1);
    end

endmodule
